sdram_slot_sched: RTL
=====================

# sdram_slot_sched

Four-port scheduler sharing the single SDRAM controller between the 68k/DMA read path, sprite (C ROM) burst fetch, fix (S ROM) fetch and the CD write path. It latches request edges, arbitrates with fixed priority plus per-port starvation aging, and runs the one-outstanding-access READY handshake. It captures read data and reports per-port completion. It sits between the requesters and the SDRAM controller; address/data muxing stays outside and is driven from `GNT_SEL`.

## Interface
Parameters:
- `STARVE_MAX`, 8: losses while pending before a port is force-granted (2..255)

Ports:
- `CLK`  in  1  system clock
- `nRESET`  in  1  synchronous, active-low reset
- `REQ`  in  4  request levels; bit0 68k rd, bit1 CROM rd, bit2 SROM rd, bit3 CD wr; rising edge = one request
- `HOLD`  in  1  blocks new grants (HPS download); running access completes
- `GNT_SEL`  out  2  index of granted/running port, valid while `BUSY`
- `BUSY`  out  1  access issued and not yet complete
- `DONE`  out  4  one-cycle completion pulse, one-hot
- `RD_DATA`  out  64  read data, updated with `DONE`
- `SDRAM_RD`  out  1  read command level
- `SDRAM_WR`  out  1  write command level
- `SDRAM_BURST`  out  1  4-word burst (port 1 only)
- `SDRAM_READY`  in  1  controller idle
- `SDRAM_DOUT`  in  64  controller read data

## Operation
- Edge detect: `edge[i] = REQ[i] & ~req_prev[i]`, with `req_prev` registered every cycle. An edge sets `pend[i]`. An edge on an already pending port is merged. An edge on the running port sets `pend` again, so it is re-queued.
- FSM `IDLE -> ISSUE -> WAIT -> IDLE`:
  - IDLE: if `~HOLD & SDRAM_READY & |(pend|edge)`, pick the winner, clear its `pend`, set `GNT_SEL`/`BUSY`, assert `SDRAM_RD`, or `SDRAM_WR` for port 3. `SDRAM_BURST = (winner==1)`. Go to ISSUE.
  - ISSUE: on `SDRAM_READY` falling (registered previous value high, current low), drop RD/WR and go to WAIT.
  - WAIT: on `SDRAM_READY==1`, latch `RD_DATA<=SDRAM_DOUT` for read ports (port 3 leaves it unchanged) and pulse `DONE[GNT_SEL]`. Clear `BUSY`. Arbitrate again in this same cycle under the IDLE rules; this is back-to-back issue.
- Arbitration: among candidates, starved ports (`age[i]==STARVE_MAX`) win first, lowest index among them. Otherwise fixed priority 0>1>2>3.
- Aging: ports 1..3 each have an 8-bit `age`. A port's `age` increments, saturating at STARVE_MAX, when it is pending and another port is granted. It clears when the port is granted. Port 0 has no aging.
- HOLD: pending requests are kept, edges are still latched, ages are frozen.
- Reset (`nRESET==0` at an edge), including mid-access: FSM to IDLE and all state cleared. Any late READY rise from the aborted access is ignored.

## Timing
- Reset values: `GNT_SEL=0`, `BUSY=0`, `DONE=0`, `RD_DATA=0`, `SDRAM_RD=0`, `SDRAM_WR=0`, `SDRAM_BURST=0`; `pend`, `age`, `req_prev` are 0, and the registered READY is 1.
- Request to command: an edge seen in cycle t with the FSM idle gives RD/WR high after the edge ending cycle t. Latency is 1 clock.
- The command stays high until the first cycle READY is seen low, then drops on the next edge.
- `DONE`/`RD_DATA` are registered one clock after READY is sampled high in WAIT. The next command is asserted at that same edge.
- RD and WR are never high together. At most one `DONE` bit is set per cycle.
- `edge` and completion in the same cycle: the new edge takes part in that cycle's arbitration.

## Structure
- Shared package `neogeo_mem_pkg`: port index constants (`PORT_M68K=0`, `PORT_CROM=1`, `PORT_SROM=2`, `PORT_CDWR=3`) and the FSM state enum.
- One sub-module `slot_prio_pick`: combinational winner select from `cand[3:0]` and `starved[3:0]`, returning index and valid. Sequential logic stays in the top module.

## Test plan
- Single read: `REQ[2]` 0→1 with READY modelled to fall 2 cycles after RD and rise 3 cycles later with DOUT=64'h1234 → `SDRAM_RD` high 1 clock after the edge, `BURST=0`, `DONE=4'b0100` one cycle, `RD_DATA=64'h1234`.
- Simultaneous edges on REQ[3:0]=4'hF → grant order 0,1,2,3. `SDRAM_BURST` is set only for port 1. Port 3 uses WR and leaves `RD_DATA` unchanged.
- Starvation, STARVE_MAX=8: port 3 stays pending while ports 0/1 re-request continuously → port 3 is granted on its 9th arbitration. Its age then returns to 0.
- HOLD: with HOLD=1, pulse REQ[1] → no command issued. Release HOLD → issue 1 clock later, with `age` values unchanged.
- Back-to-back: REQ[0] edge arrives during the WAIT of a port-2 access → `DONE[2]` and `SDRAM_RD` for port 0 are asserted on the same edge. A re-edge on running port 2 gives a second port-2 access afterwards.
- Reset mid-WAIT: nRESET=0 for 1 cycle → all outputs at reset values the next cycle. A READY rise afterwards produces no `DONE`.

Source files
------------

// File: rtl/neogeo_mem_pkg.sv
// rtl/neogeo_mem_pkg.sv - shared port indices and scheduler state encoding
package neogeo_mem_pkg;

  localparam logic [1:0] PORT_M68K = 2'd0;
  localparam logic [1:0] PORT_CROM = 2'd1;
  localparam logic [1:0] PORT_SROM = 2'd2;
  localparam logic [1:0] PORT_CDWR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/slot_prio_pick.sv
// rtl/slot_prio_pick.sv - combinational winner select: starved ports first, then lowest index
module slot_prio_pick (
  input  logic [3:0] cand,
  input  logic [3:0] starved,
  output logic [1:0] idx,
  output logic       valid
);

  logic [3:0] pool;

  always_comb begin
    pool  = ((cand & starved) != 4'd0) ? (cand & starved) : cand;
    valid = (cand != 4'd0);
    idx   = 2'd0;
    // descending scan so the lowest set index is written last
    for (int i = 3; i >= 0; i--) begin
      if (pool[i]) idx = 2'(i);
    end
  end

endmodule

// File: rtl/sdram_slot_sched.sv
// rtl/sdram_slot_sched.sv - four-port SDRAM slot scheduler with aging and READY handshake
module sdram_slot_sched
  import neogeo_mem_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic [3:0]  REQ,
  input  logic        HOLD,
  output logic [1:0]  GNT_SEL,
  output logic        BUSY,
  output logic [3:0]  DONE,
  output logic [63:0] RD_DATA,
  output logic        SDRAM_RD,
  output logic        SDRAM_WR,
  output logic        SDRAM_BURST,
  input  logic        SDRAM_READY,
  input  logic [63:0] SDRAM_DOUT
);

  localparam logic [7:0] AGE_MAX = 8'(STARVE_MAX);

  sched_state_t state, state_next;

  logic [3:0] req_prev;
  logic [3:0] pend;
  logic [7:0] age [1:3];
  logic       ready_q;

  logic [3:0] req_edge;
  logic [3:0] cand;
  logic [3:0] starved;
  logic [3:0] win_mask;
  logic [1:0] win_idx;
  logic       win_valid;
  logic       complete;
  logic       grant;
  logic       cmd_drop;

  assign req_edge = REQ & ~req_prev;
  assign cand     = pend | req_edge;
  assign win_mask = 4'b0001 << win_idx;

  always_comb begin
    starved[0] = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      starved[i] = (age[i] == AGE_MAX);
    end
  end

  slot_prio_pick u_pick (
    .cand    (cand),
    .starved (starved),
    .idx     (win_idx),
    .valid   (win_valid)
  );

  // completion in WAIT doubles as an arbitration slot for back-to-back issue
  always_comb begin
    complete   = (state == ST_WAIT) && SDRAM_READY;
    grant      = ((state == ST_IDLE) || complete) && !HOLD && SDRAM_READY && win_valid;
    cmd_drop   = (state == ST_ISSUE) && ready_q && !SDRAM_READY;
    state_next = state;
    case (state)
      ST_IDLE:  if (grant) state_next = ST_ISSUE;
      ST_ISSUE: if (cmd_drop) state_next = ST_WAIT;
      ST_WAIT:  if (complete) state_next = grant ? ST_ISSUE : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      req_prev    <= '0;
      pend        <= '0;
      ready_q     <= 1'b1;
      GNT_SEL     <= '0;
      BUSY        <= 1'b0;
      DONE        <= '0;
      RD_DATA     <= '0;
      SDRAM_RD    <= 1'b0;
      SDRAM_WR    <= 1'b0;
      SDRAM_BURST <= 1'b0;
      for (int i = 1; i <= 3; i++) age[i] <= '0;
    end else begin
      req_prev <= REQ;
      ready_q  <= SDRAM_READY;
      DONE     <= '0;
      pend     <= grant ? (cand & ~win_mask) : cand;

      if (cmd_drop) begin
        SDRAM_RD    <= 1'b0;
        SDRAM_WR    <= 1'b0;
        SDRAM_BURST <= 1'b0;
      end

      if (complete) begin
        DONE <= 4'b0001 << GNT_SEL;
        if (GNT_SEL != PORT_CDWR) RD_DATA <= SDRAM_DOUT;
        BUSY <= 1'b0;
      end

      if (grant) begin
        GNT_SEL     <= win_idx;
        BUSY        <= 1'b1;
        SDRAM_RD    <= (win_idx != PORT_CDWR);
        SDRAM_WR    <= (win_idx == PORT_CDWR);
        SDRAM_BURST <= (win_idx == PORT_CROM);
        for (int i = 1; i <= 3; i++) begin
          if (win_idx == 2'(i))                     age[i] <= '0;
          else if (cand[i] && (age[i] != AGE_MAX)) age[i] <= age[i] + 8'd1;
        end
      end
    end
  end

endmodule
